// File: rtl/bf_inverse_pipe.sv
// bf_inverse_pipe: three-stage radix-2 inverse butterfly, x = y0 +/- y1*conj(w), saturated, valid/ready
module bf_inverse_pipe #(
  parameter int WIDTH = 16,
  parameter bit RND = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] y0_real,
  input  logic signed [WIDTH-1:0] y0_img,
  input  logic signed [WIDTH-1:0] y1_real,
  input  logic signed [WIDTH-1:0] y1_img,
  input  logic signed [WIDTH-1:0] w_real,
  input  logic signed [WIDTH-1:0] w_img,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x0_real,
  output logic signed [WIDTH-1:0] x0_img,
  output logic signed [WIDTH-1:0] x1_real,
  output logic signed [WIDTH-1:0] x1_img,
  output logic                    out_sat
);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW:0] RC = RND ? (PW + 1)'(1) <<< (WIDTH - 2) : '0;
  localparam logic signed [WIDTH+1:0] MAXV = {3'b000, {(WIDTH - 1){1'b1}}};
  localparam logic signed [WIDTH+1:0] MINV = {3'b111, {(WIDTH - 1){1'b0}}};
  logic v1, v2, v3, adv;
  logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
  logic signed [WIDTH-1:0] y0r1, y0i1, y0r2, y0i2;
  logic signed [WIDTH:0] tr2, ti2;
  logic signed [PW:0] sr, si;
  logic signed [WIDTH+1:0] s0r, s0i, s1r, s1i;
  logic [3:0] ov;
  function automatic logic signed [WIDTH-1:0] clip(input logic signed [WIDTH+1:0] v);
    return v > MAXV ? MAXV[WIDTH-1:0] : v < MINV ? MINV[WIDTH-1:0] : v[WIDTH-1:0];
  endfunction
  function automatic logic ovf(input logic signed [WIDTH+1:0] v);
    return (v > MAXV) | (v < MINV);
  endfunction
  assign adv = !v3 | out_ready;
  assign in_ready = adv;
  assign out_valid = v3;
  // t is kept at WIDTH+1 bits so that a twiddle of exactly -1.0 does not wrap
  always_comb begin
    sr = (PW + 1)'(p_rr) + (PW + 1)'(p_ii) + RC;
    si = (PW + 1)'(p_ir) - (PW + 1)'(p_ri) + RC;
    s0r = (WIDTH + 2)'(y0r2) + (WIDTH + 2)'(tr2);
    s0i = (WIDTH + 2)'(y0i2) + (WIDTH + 2)'(ti2);
    s1r = (WIDTH + 2)'(y0r2) - (WIDTH + 2)'(tr2);
    s1i = (WIDTH + 2)'(y0i2) - (WIDTH + 2)'(ti2);
    ov = {ovf(s0r), ovf(s0i), ovf(s1r), ovf(s1i)};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ir <= '0;
      p_ri <= '0;
      y0r1 <= '0;
      y0i1 <= '0;
      y0r2 <= '0;
      y0i2 <= '0;
      tr2 <= '0;
      ti2 <= '0;
      x0_real <= '0;
      x0_img <= '0;
      x1_real <= '0;
      x1_img <= '0;
      out_sat <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      p_rr <= PW'(y1_real) * PW'(w_real);
      p_ii <= PW'(y1_img) * PW'(w_img);
      p_ir <= PW'(y1_img) * PW'(w_real);
      p_ri <= PW'(y1_real) * PW'(w_img);
      y0r1 <= y0_real;
      y0i1 <= y0_img;
      y0r2 <= y0r1;
      y0i2 <= y0i1;
      tr2 <= (WIDTH + 1)'(sr >>> (WIDTH - 1));
      ti2 <= (WIDTH + 1)'(si >>> (WIDTH - 1));
      x0_real <= clip(s0r);
      x0_img <= clip(s0i);
      x1_real <= clip(s1r);
      x1_img <= clip(s1i);
      out_sat <= |ov;
    end
  end
endmodule

// File: tb/tb_bf_inverse_pipe.sv
// tb_bf_inverse_pipe: directed and random checks of the inverse butterfly, RND=1 and RND=0 instances side by side
module tb_bf_inverse_pipe;
  typedef struct {
    logic signed [15:0] y0r, y0i, y1r, y1i, wr, wi;
  } pair_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [15:0] y0r = 0, y0i = 0, y1r = 0, y1i = 0, wr = 0, wi = 0;
  logic in_ready, out_valid, out_sat, in_ready_t, out_valid_t, out_sat_t;
  logic signed [15:0] x0r, x0i, x1r, x1i, x0r_t, x0i_t, x1r_t, x1i_t;
  int n_chk = 0, n_fail = 0;
  pair_t q[$];
  always #5 clk = ~clk;
  bf_inverse_pipe #(.WIDTH(16), .RND(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .y0_real(y0r), .y0_img(y0i), .y1_real(y1r), .y1_img(y1i), .w_real(wr), .w_img(wi),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0_real(x0r), .x0_img(x0i), .x1_real(x1r), .x1_img(x1i), .out_sat(out_sat));
  bf_inverse_pipe #(.WIDTH(16), .RND(1'b0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .y0_real(y0r), .y0_img(y0i), .y1_real(y1r), .y1_img(y1i), .w_real(wr), .w_img(wi),
    .out_valid(out_valid_t), .out_ready(out_ready),
    .x0_real(x0r_t), .x0_img(x0i_t), .x1_real(x1r_t), .x1_img(x1i_t), .out_sat(out_sat_t));
  task automatic check(input string tag, input logic signed [127:0] obs, input logic signed [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int wrap17(input longint v);
    int u;
    u = int'(v & 64'h1FFFF);
    return u > 65535 ? u - 131072 : u;
  endfunction
  function automatic logic [64:0] model(input pair_t p, input bit rnd);
    longint pr, pi;
    int t_r, t_i;
    int a[4];
    logic s;
    logic [63:0] d;
    s = 1'b0;
    d = '0;
    pr = longint'(p.y1r) * longint'(p.wr) + longint'(p.y1i) * longint'(p.wi) + (rnd ? 16384 : 0);
    pi = longint'(p.y1i) * longint'(p.wr) - longint'(p.y1r) * longint'(p.wi) + (rnd ? 16384 : 0);
    t_r = wrap17(pr >>> 15);
    t_i = wrap17(pi >>> 15);
    a[0] = p.y0r + t_r;
    a[1] = p.y0i + t_i;
    a[2] = p.y0r - t_r;
    a[3] = p.y0i - t_i;
    for (int k = 0; k < 4; k++) begin
      if (a[k] > 32767) begin a[k] = 32767; s = 1'b1; end
      else if (a[k] < -32768) begin a[k] = -32768; s = 1'b1; end
      d = {d[47:0], 16'(a[k])};
    end
    return {s, d};
  endfunction
  task automatic drive(input pair_t p);
    y0r = p.y0r; y0i = p.y0i; y1r = p.y1r; y1i = p.y1i; wr = p.wr; wi = p.wi;
  endtask
  function automatic pair_t mk(input int a, b, c, d, e, f);
    pair_t p;
    p.y0r = 16'(a); p.y0i = 16'(b); p.y1r = 16'(c); p.y1i = 16'(d); p.wr = 16'(e); p.wi = 16'(f);
    return p;
  endfunction
  // one isolated pair: result must appear on the third rising edge counted from the accepting one
  task automatic run1(input string tag, input pair_t p, input int e0r, e0i, e1r, e1i, input bit es);
    @(negedge clk);
    drive(p);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat3"}, out_valid, 1);
    check({tag, "_x0"}, {x0r, x0i}, {16'(e0r), 16'(e0i)});
    check({tag, "_x1"}, {x1r, x1i}, {16'(e1r), 16'(e1i)});
    check({tag, "_sat"}, out_sat, es);
  endtask
  task automatic stream(input int n, input bit rnd_mode, input string tag);
    int sent = 0, cyc = 0;
    bit stall_prev = 1'b0, dropped = 1'b0;
    logic [64:0] held = '0;
    pair_t p;
    in_valid = 1'b0;
    out_ready = 1'b1;
    q.delete();
    @(negedge clk);
    while ((sent < n || q.size() > 0) && cyc < 20 * n + 100) begin
      @(negedge clk);
      p = mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      if ($urandom_range(0, 7) == 0) p.wr = -16'sd32768;
      drive(p);
      in_valid = sent < n && (rnd_mode ? $urandom_range(0, 3) != 0 : 1'b1);
      out_ready = rnd_mode ? $urandom_range(0, 2) != 0 : !(cyc >= 2 && cyc <= 6);
      #1;
      if (!rnd_mode && !in_ready && !dropped) begin
        dropped = 1'b1;
        check({tag, "_capacity"}, sent, 3);
      end
      if (stall_prev) check({tag, "_hold"}, {out_valid, out_sat, x0r, x0i, x1r, x1i}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0) check({tag, "_spurious"}, out_valid, 0);
        else begin
          check({tag, "_rnd1"}, {out_sat, x0r, x0i, x1r, x1i}, model(q[0], 1'b1));
          check({tag, "_rnd0"}, {out_sat_t, x0r_t, x0i_t, x1r_t, x1i_t}, model(q[0], 1'b0));
          void'(q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_sat, x0r, x0i, x1r, x1i};
      if (in_valid && in_ready) begin
        q.push_back(p);
        sent++;
      end
      cyc++;
    end
    check({tag, "_drained"}, q.size() + (n - sent), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask
  initial begin
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_x", {x0r, x0i, x1r, x1i}, 0);
    check("reset_sat", out_sat, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    run1("identity", mk(1000, 0, 2000, 0, 32767, 0), 3000, 0, -1000, 0, 1'b0);
    check("identity_trunc", {x0r_t, x1r_t}, {16'sd2999, -16'sd999});
    run1("conjugate", mk(0, 0, 0, 1000, 0, 32767), 1000, 0, -1000, 0, 1'b0);
    run1("sat_pos", mk(30000, 0, 30000, 0, 32767, 0), 32767, 0, 1, 0, 1'b1);
    run1("sat_neg", mk(-32768, 0, 32767, 0, 32767, 0), -2, 0, -32768, 0, 1'b1);
    run1("minus_j", mk(100, -200, 16384, 8192, 0, -32768), -8092, 16184, 8292, -16584, 1'b0);
    stream(10, 1'b0, "backpressure");
    stream(1000, 1'b1, "random");
    @(negedge clk);
    drive(mk(1, 2, 3, 4, 5, 6));
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #1 check("midreset_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", out_valid, 0);
    check("midreset_x", {x0r, x0i, x1r, x1i}, 0);
    check("midreset_sat", out_sat, 0);
    check("midreset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_no_stale", out_valid, 0);
    run1("after_reset", mk(1000, 0, 2000, 0, 32767, 0), 3000, 0, -1000, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
